// File: rtl/demux_1to4.sv
// 1-to-4 demultiplexer with a private FIFO per destination; depth 2 with
// DEMUX_SKID_EN defined (full rate per destination), depth 1 otherwise.
module demux_1to4 #(
   parameter int unsigned PLD_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             vld_src,
   input  logic [PLD_W-1:0] pld_src,
   input  logic [1:0]       sel_src,
   output logic             rdy_src,
   output logic             vld_dst0,
   output logic             vld_dst1,
   output logic             vld_dst2,
   output logic             vld_dst3,
   output logic [PLD_W-1:0] pld_dst0,
   output logic [PLD_W-1:0] pld_dst1,
   output logic [PLD_W-1:0] pld_dst2,
   output logic [PLD_W-1:0] pld_dst3,
   input  logic             rdy_dst0,
   input  logic             rdy_dst1,
   input  logic             rdy_dst2,
   input  logic             rdy_dst3,
   output logic             busy
);

`ifdef DEMUX_SKID_EN
   localparam int unsigned DEPTH = 2;
`else
   localparam int unsigned DEPTH = 1;
`endif
   localparam int unsigned NDST = 4;

   logic [1:0]       r_cnt  [NDST];
   logic [PLD_W-1:0] r_head [NDST];
`ifdef DEMUX_SKID_EN
   logic [PLD_W-1:0] r_tail [NDST];
   logic [PLD_W-1:0] w_tail_nxt [NDST];
`endif

   logic [1:0]       w_cnt_nxt  [NDST];
   logic [PLD_W-1:0] w_head_nxt [NDST];
   logic [NDST-1:0]  w_rdy_dst;
   logic [NDST-1:0]  w_push;
   logic [NDST-1:0]  w_pop;

   assign w_rdy_dst = {rdy_dst3, rdy_dst2, rdy_dst1, rdy_dst0};

   // Acceptance looks only at the selected buffer's registered occupancy.
   assign rdy_src = (r_cnt[sel_src] < 2'(DEPTH));

   always_comb begin
      w_push = '0;
      w_pop  = '0;
      for (int k = 0; k < int'(NDST); k++) begin
         w_cnt_nxt[k]  = r_cnt[k];
         w_head_nxt[k] = r_head[k];
`ifdef DEMUX_SKID_EN
         w_tail_nxt[k] = r_tail[k];
`endif
         w_pop[k]  = (r_cnt[k] != 2'd0) && w_rdy_dst[k];
         w_push[k] = vld_src && rdy_src && (sel_src == 2'(k));

         case ({w_push[k], w_pop[k]})
            2'b10:   w_cnt_nxt[k] = r_cnt[k] + 2'd1;
            2'b01:   w_cnt_nxt[k] = r_cnt[k] - 2'd1;
            default: w_cnt_nxt[k] = r_cnt[k];
         endcase

`ifdef DEMUX_SKID_EN
         if (w_pop[k]) begin
            w_head_nxt[k] = r_tail[k];
         end
         // Write slot is the occupancy left after this cycle's pop.
         if (w_push[k]) begin
            if ((r_cnt[k] - 2'(w_pop[k])) == 2'd0) begin
               w_head_nxt[k] = pld_src;
            end else begin
               w_tail_nxt[k] = pld_src;
            end
         end
`else
         if (w_push[k]) begin
            w_head_nxt[k] = pld_src;
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < int'(NDST); k++) begin
            r_cnt[k]  <= 2'd0;
            r_head[k] <= '0;
`ifdef DEMUX_SKID_EN
            r_tail[k] <= '0;
`endif
         end
      end else begin
         for (int k = 0; k < int'(NDST); k++) begin
            r_cnt[k]  <= w_cnt_nxt[k];
            r_head[k] <= w_head_nxt[k];
`ifdef DEMUX_SKID_EN
            r_tail[k] <= w_tail_nxt[k];
`endif
         end
      end
   end

   assign vld_dst0 = (r_cnt[0] != 2'd0);
   assign vld_dst1 = (r_cnt[1] != 2'd0);
   assign vld_dst2 = (r_cnt[2] != 2'd0);
   assign vld_dst3 = (r_cnt[3] != 2'd0);
   assign pld_dst0 = r_head[0];
   assign pld_dst1 = r_head[1];
   assign pld_dst2 = r_head[2];
   assign pld_dst3 = r_head[3];
   assign busy     = vld_dst0 | vld_dst1 | vld_dst2 | vld_dst3;

endmodule

// File: tb/tb_demux_1to4.sv
// Bench for demux_1to4: vector table for routing/backpressure basics plus
// directed sequences for reset, ordering, isolation and throughput.
module tb_demux_1to4;

`ifdef DEMUX_SKID_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 1;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       vld_src;
   logic [3:0] pld_src;
   logic [1:0] sel_src;
   logic       rdy_src;
   logic       vld_dst0, vld_dst1, vld_dst2, vld_dst3;
   logic [3:0] pld_dst0, pld_dst1, pld_dst2, pld_dst3;
   logic       rdy_dst0, rdy_dst1, rdy_dst2, rdy_dst3;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc;

   logic [3:0] got [4][32];
   int         n_got [4];

   demux_1to4 #(.PLD_W(4)) dut (
      .clk(clk), .rst(rst),
      .vld_src(vld_src), .pld_src(pld_src), .sel_src(sel_src), .rdy_src(rdy_src),
      .vld_dst0(vld_dst0), .vld_dst1(vld_dst1), .vld_dst2(vld_dst2), .vld_dst3(vld_dst3),
      .pld_dst0(pld_dst0), .pld_dst1(pld_dst1), .pld_dst2(pld_dst2), .pld_dst3(pld_dst3),
      .rdy_dst0(rdy_dst0), .rdy_dst1(rdy_dst1), .rdy_dst2(rdy_dst2), .rdy_dst3(rdy_dst3),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Record every destination handshake in arrival order.
   always @(posedge clk) begin
      if (!rst) begin
         if (vld_dst0 && rdy_dst0 && n_got[0] < 32) begin got[0][n_got[0]] = pld_dst0; n_got[0]++; end
         if (vld_dst1 && rdy_dst1 && n_got[1] < 32) begin got[1][n_got[1]] = pld_dst1; n_got[1]++; end
         if (vld_dst2 && rdy_dst2 && n_got[2] < 32) begin got[2][n_got[2]] = pld_dst2; n_got[2]++; end
         if (vld_dst3 && rdy_dst3 && n_got[3] < 32) begin got[3][n_got[3]] = pld_dst3; n_got[3]++; end
      end
   end

   typedef struct {
      logic       vld;
      logic [1:0] sel;
      logic [3:0] pld;
      logic [3:0] rdy;
      logic       exp_rdy;
      logic [3:0] exp_vld;
      logic [3:0] exp_pld [4];
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic v, input logic [1:0] s, input logic [3:0] p,
                               input logic [3:0] r, input logic er, input logic [3:0] ev,
                               input logic [3:0] p0, input logic [3:0] p1,
                               input logic [3:0] p2, input logic [3:0] p3);
      vec_t t;
      t.vld = v; t.sel = s; t.pld = p; t.rdy = r; t.exp_rdy = er; t.exp_vld = ev;
      t.exp_pld[0] = p0; t.exp_pld[1] = p1; t.exp_pld[2] = p2; t.exp_pld[3] = p3;
      return t;
   endfunction

   function automatic logic [3:0] dst_vld();
      return {vld_dst3, vld_dst2, vld_dst1, vld_dst0};
   endfunction

   function automatic logic [3:0] dst_pld(input int k);
      case (k)
         0: return pld_dst0;
         1: return pld_dst1;
         2: return pld_dst2;
         default: return pld_dst3;
      endcase
   endfunction

   task automatic set_rdy(input logic [3:0] r);
      {rdy_dst3, rdy_dst2, rdy_dst1, rdy_dst0} = r;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a beat and hold it until accepted (bounded), then drop vld_src.
   task automatic send(input logic [1:0] s, input logic [3:0] p);
      int k;
      vld_src = 1'b1; sel_src = s; pld_src = p;
      #1;
      k = 0;
      while (!rdy_src && k < 50) begin
         tick(); cyc++; k++;
      end
      check("send_timeout", 32'(k < 50), 32'd1);
      @(posedge clk);
      cyc++;
      #1;
      vld_src = 1'b0;
   endtask

   task automatic clear_got();
      for (int k = 0; k < 4; k++) n_got[k] = 0;
   endtask

   initial begin
      logic [3:0] lo_pat;
      int         k;
      clear_got();
      vecs[0]  = mk(1, 2'd0, 4'hA, 4'hF, 1, 4'b0001, 4'hA, 0, 0, 0);
      vecs[1]  = mk(1, 2'd1, 4'hB, 4'hF, 1, 4'b0010, 0, 4'hB, 0, 0);
      vecs[2]  = mk(1, 2'd2, 4'hC, 4'hF, 1, 4'b0100, 0, 0, 4'hC, 0);
      vecs[3]  = mk(1, 2'd3, 4'hD, 4'hF, 1, 4'b1000, 0, 0, 0, 4'hD);
      vecs[4]  = mk(0, 2'd0, 4'h3, 4'hF, 1, 4'b0000, 0, 0, 0, 0);
      vecs[5]  = mk(0, 2'd1, 4'hF, 4'hF, 1, 4'b0000, 0, 0, 0, 0);
      vecs[6]  = mk(1, 2'd2, 4'h5, 4'h0, 1, 4'b0100, 0, 0, 4'h5, 0);
      vecs[7]  = mk(1, 2'd2, 4'h6, 4'h0, DEPTH == 2, 4'b0100, 0, 0, 4'h5, 0);
      vecs[8]  = mk(1, 2'd0, 4'h7, 4'h0, 1, 4'b0101, 4'h7, 0, 4'h5, 0);
      vecs[9]  = mk(0, 2'd0, 4'h0, 4'hF, DEPTH == 2,
                    (DEPTH == 2) ? 4'b0100 : 4'b0000, 0, 0, 4'h6, 0);
      vecs[10] = mk(0, 2'd2, 4'h0, 4'hF, 1, 4'b0000, 0, 0, 0, 0);

      // Reset held two cycles with a live source beat.
      rst = 1'b1; vld_src = 1'b1; sel_src = 2'd2; pld_src = 4'h9; set_rdy(4'h0);
      tick(); tick();
      check("rst_vld", 32'(dst_vld()), 32'd0);
      for (int i = 0; i < 4; i++) check("rst_pld", 32'(dst_pld(i)), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0; vld_src = 1'b0;
      #1;
      check("rst_rdy_src", 32'(rdy_src), 32'd1);

      // Table-driven single-cycle vectors.
      for (int v = 0; v < 11; v++) begin
         vld_src = vecs[v].vld; sel_src = vecs[v].sel; pld_src = vecs[v].pld;
         set_rdy(vecs[v].rdy);
         #1;
         check($sformatf("v%0d_rdy_src", v), 32'(rdy_src), 32'(vecs[v].exp_rdy));
         tick();
         check($sformatf("v%0d_vld", v), 32'(dst_vld()), 32'(vecs[v].exp_vld));
         check($sformatf("v%0d_busy", v), 32'(busy), 32'(|vecs[v].exp_vld));
         for (int i = 0; i < 4; i++)
            if (vecs[v].exp_vld[i])
               check($sformatf("v%0d_pld%0d", v, i), 32'(dst_pld(i)), 32'(vecs[v].exp_pld[i]));
      end
      vld_src = 1'b0;

      // Backpressure on destination 1: head holds, then ordered drain.
      set_rdy(4'b1101); clear_got(); tick();
      vld_src = 1'b1; sel_src = 2'd1;
      for (int i = 0; i < 3; i++) begin
         pld_src = 4'(i + 1);
         #1;
         check("bp_rdy_src", 32'(rdy_src), 32'(i < DEPTH));
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         check("bp_hold_vld", 32'(vld_dst1), 32'd1);
         check("bp_hold_pld", 32'(pld_dst1), 32'd1);
         tick();
      end
      vld_src = 1'b0;
      set_rdy(4'hF);
      for (int i = DEPTH; i < 3; i++) send(2'd1, 4'(i + 1));
      repeat (4) tick();
      check("bp_count", 32'(n_got[1]), 32'd3);
      for (int i = 0; i < 3; i++) check("bp_order", 32'(got[1][i]), 32'(i + 1));
      check("bp_other", 32'(n_got[0] + n_got[2] + n_got[3]), 32'd0);

      // Full destination 0 must not stall a beat to destination 3.
      set_rdy(4'b1110);
      for (int i = 0; i < DEPTH; i++) send(2'd0, 4'(i + 2));
      vld_src = 1'b1; sel_src = 2'd0; pld_src = 4'hF;
      #1;
      check("hol_full_rdy", 32'(rdy_src), 32'd0);
      sel_src = 2'd3; pld_src = 4'hE;
      #1;
      check("hol_switch_rdy", 32'(rdy_src), 32'd1);
      tick();
      vld_src = 1'b0;
      check("hol_vld3", 32'(vld_dst3), 32'd1);
      check("hol_pld3", 32'(pld_dst3), 32'hE);
      check("hol_pld0", 32'(pld_dst0), 32'd2);
      set_rdy(4'hF);
      repeat (4) tick();
      check("hol_drained", 32'(busy), 32'd0);

      // Throughput: 16 beats to destination 2, measured until the source could take a 17th.
      clear_got(); cyc = 0;
      for (int i = 0; i < 16; i++) send(2'd2, 4'(i));
      sel_src = 2'd2;
      #1;
      k = 0;
      while (!rdy_src && k < 10) begin tick(); cyc++; k++; end
      check("tput_cycles", 32'(cyc), 32'(32 / DEPTH));
      repeat (4) tick();
      check("tput_count", 32'(n_got[2]), 32'd16);
      for (int i = 0; i < 16; i++) check("tput_order", 32'(got[2][i]), 32'(i));

      // Mid-operation reset discards buffered beats.
      set_rdy(4'b1101); clear_got();
      for (int i = 0; i < DEPTH; i++) send(2'd1, 4'(i + 8));
      check("mrst_pre_vld1", 32'(vld_dst1), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mrst_vld1", 32'(vld_dst1), 32'd0);
      check("mrst_busy", 32'(busy), 32'd0);
      for (int s = 0; s < 4; s++) begin
         sel_src = 2'(s);
         #1;
         check("mrst_rdy_src", 32'(rdy_src), 32'd1);
      end
      set_rdy(4'hF);
      repeat (4) tick();
      check("mrst_no_delivery", 32'(n_got[1]), 32'd0);
      lo_pat = dst_vld();
      check("mrst_idle", 32'(lo_pat), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
